// File: rtl/spi_master_sck_gen_if.sv
// Handshake and SPI clock-generator signal bundle shared by the master control FSM
// (master modport) and the serial-clock generator (slave modport).
interface spi_master_sck_gen_if #(
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 8
);
  logic [DIV_WIDTH-1:0] clk_div;
  logic                 clk_div_valid;
  logic                 cpol;
  logic                 cpha;
  logic [CNT_WIDTH-1:0] num_bits;
  logic                 start;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic                 spi_clk;
  logic                 spi_sample;
  logic                 spi_shift;

  modport master (
    output clk_div, clk_div_valid, cpol, cpha, num_bits, start, abort,
    input  busy, done, spi_clk, spi_sample, spi_shift
  );

  modport slave (
    input  clk_div, clk_div_valid, cpol, cpha, num_bits, start, abort,
    output busy, done, spi_clk, spi_sample, spi_shift
  );
endinterface

// File: rtl/spi_master_sck_gen.sv
// SPI master serial-clock generator: one N-bit transfer per start, all four CPOL/CPHA
// modes, half-period setup/hold around the clock burst, single-cycle sample/shift strobes.
module spi_master_sck_gen #(
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  spi_master_sck_gen_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, HOLD} state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic                 lat_cpol_q, lat_cpol_d;
  logic                 lat_cpha_q, lat_cpha_d;
  logic [CNT_WIDTH-1:0] lat_n_q, lat_n_d;
  logic [CNT_WIDTH:0]   edge_q, edge_d;
  logic                 spi_clk_q, spi_clk_d;
  logic                 sample_q, sample_d;
  logic                 shift_q, shift_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 tick;
  logic                 go_idle;
  logic [CNT_WIDTH:0]   edge_nxt;
  logic [CNT_WIDTH:0]   last_edge;
  logic [1:0]           strobes;

  // {sample, shift} for edge e. With CPHA=0 the first bit is preloaded at start,
  // so the final trailing edge carries no shift.
  function automatic logic [1:0] strobe_sel(input logic [CNT_WIDTH:0] e,
                                            input logic               pha,
                                            input logic [CNT_WIDTH:0] last);
    logic smp;
    smp = e[0] ^ pha;
    return {smp, ~smp & ~(~pha & (e == last))};
  endfunction

  assign tick      = (cnt_q == div_q);
  assign edge_nxt  = edge_q + (CNT_WIDTH+1)'(1);
  assign last_edge = {lat_n_q, 1'b0};
  assign strobes   = strobe_sel(edge_nxt, lat_cpha_q, last_edge);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    lat_cpol_d = lat_cpol_q;
    lat_cpha_d = lat_cpha_q;
    lat_n_d    = lat_n_q;
    edge_d     = edge_q;
    spi_clk_d  = spi_clk_q;
    sample_d   = 1'b0;
    shift_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    go_idle    = 1'b0;

    if (state_q == IDLE) begin
      spi_clk_d = bus.cpol;
      busy_d    = 1'b0;
      cnt_d     = '0;
      if (bus.clk_div_valid) div_d = bus.clk_div;
      if (bus.start) begin
        if (bus.num_bits != '0) begin
          state_d    = SETUP;
          lat_cpol_d = bus.cpol;
          lat_cpha_d = bus.cpha;
          lat_n_d    = bus.num_bits;
          edge_d     = '0;
          busy_d     = 1'b1;
        end else begin
          done_d = 1'b1;
        end
      end
    end else begin
      // Divider writes during a transfer are parked until the FSM is back in IDLE.
      cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
      if (bus.clk_div_valid) begin
        pend_d     = bus.clk_div;
        pend_vld_d = 1'b1;
      end
      if (bus.abort) begin
        state_d   = IDLE;
        spi_clk_d = lat_cpol_q;
        busy_d    = 1'b0;
        go_idle   = 1'b1;
      end else if (tick) begin
        case (state_q)
          SETUP, RUN: begin
            spi_clk_d = ~spi_clk_q;
            edge_d    = edge_nxt;
            sample_d  = strobes[1];
            shift_d   = strobes[0];
            state_d   = (edge_nxt == last_edge) ? HOLD : RUN;
          end
          HOLD: begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            go_idle = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
      if (go_idle) begin
        if (bus.clk_div_valid)  div_d = bus.clk_div;
        else if (pend_vld_q)    div_d = pend_q;
        pend_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      lat_cpol_q <= 1'b0;
      lat_cpha_q <= 1'b0;
      lat_n_q    <= '0;
      edge_q     <= '0;
      spi_clk_q  <= 1'b0;
      sample_q   <= 1'b0;
      shift_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      lat_cpol_q <= lat_cpol_d;
      lat_cpha_q <= lat_cpha_d;
      lat_n_q    <= lat_n_d;
      edge_q     <= edge_d;
      spi_clk_q  <= spi_clk_d;
      sample_q   <= sample_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.spi_clk    = spi_clk_q;
  assign bus.spi_sample = sample_q;
  assign bus.spi_shift  = shift_q;

endmodule
